// File: rtl/ladder_ifetch_responder_if.sv
// Fetch-port bundle between the Ladder core's icache port and the
// instruction-fetch responder. The core drives the request half and the
// responder drives the ready/response half.
interface ladder_ifetch_responder_if #(
    parameter int INSN_PER_FETCH = 2,
    parameter int ADDR_W         = 64
);

    logic                          io_o_addr_valid;
    logic [ADDR_W-1:0]             io_o_addr;
    logic                          io_o_wen;
    logic                          io_i_addr_ready;
    logic                          io_i_data_valid;
    logic [32*INSN_PER_FETCH-1:0]  io_i_data;

    modport master (
        output io_o_addr_valid,
        output io_o_addr,
        output io_o_wen,
        input  io_i_addr_ready,
        input  io_i_data_valid,
        input  io_i_data
    );

    modport slave (
        input  io_o_addr_valid,
        input  io_o_addr,
        input  io_o_wen,
        output io_i_addr_ready,
        output io_i_data_valid,
        output io_i_data
    );

endinterface

// File: rtl/ladder_ifetch_responder.sv
// Instruction-fetch responder for the Ladder core's icache port.
// Accepts one fetch at a time, waits a configurable latency (stretched by
// stall_req while waiting), then returns INSN_PER_FETCH consecutive words
// from a preloadable, word-addressed store as a one-cycle data_valid pulse.
// Misaligned or out-of-range fetches answer with NOPs and raise a sticky err;
// a write-enable on the fetch port also raises err but returns normal data.
module ladder_ifetch_responder #(
    parameter int INSN_PER_FETCH = 2,
    parameter int DEPTH          = 256,
    parameter int LATENCY        = 1,
    parameter int ADDR_W         = 64
) (
    input  logic                      clock,
    input  logic                      resetn,
    ladder_ifetch_responder_if.slave  bus,
    input  logic                      ld_we,
    input  logic [$clog2(DEPTH)-1:0]  ld_addr,
    input  logic [31:0]               ld_data,
    input  logic                      stall_req,
    output logic                      err,
    output logic [31:0]               fetch_count
);

    localparam int          IDX_W       = $clog2(DEPTH);
    localparam int          DATA_W      = 32 * INSN_PER_FETCH;
    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    localparam logic [3:0]  CNT_INIT    = 4'(LATENCY - 1);
    localparam bit          DIRECT_RESP = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              r_state;
    logic                r_addrReady;
    logic                r_dataValid;
    logic [DATA_W-1:0]   r_data;
    logic                r_err;
    logic [31:0]         r_fetchCount;
    logic [3:0]          r_latCount;
    logic [IDX_W-1:0]    r_index;
    logic                r_fault;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic [IDX_W-1:0]    w_reqIndex;
    logic                w_reqFault;
    logic [IDX_W-1:0]    w_srcIndex;
    logic                w_srcFault;
    logic [IDX_W-1:0]    w_laneIndex;
    logic [DATA_W-1:0]   w_packet;

    assign w_accept   = bus.io_o_addr_valid && r_addrReady;
    assign w_reqIndex = bus.io_o_addr[IDX_W+1:2];
    assign w_reqFault = (bus.io_o_addr[1:0] != 2'b00) ||
                        (bus.io_o_addr[ADDR_W-1:IDX_W+2] != '0);

    // Build the packet that a RESP entry would register this cycle: from the
    // live request when answering straight from IDLE/RESP, or from the
    // captured request when the countdown in WAIT expires. Lane indices wrap
    // modulo DEPTH through the natural IDX_W-bit truncation.
    always_comb begin
        w_srcIndex  = (r_state == WAIT) ? r_index : w_reqIndex;
        w_srcFault  = (r_state == WAIT) ? r_fault : w_reqFault;
        w_laneIndex = '0;
        w_packet    = '0;
        for (int i = 0; i < INSN_PER_FETCH; i++) begin
            w_laneIndex         = w_srcIndex + IDX_W'(i);
            w_packet[32*i +: 32] = w_srcFault ? NOP_INSN : r_mem[w_laneIndex];
        end
    end

    // Preload port; the store is never cleared so a reset keeps the program.
    // A write landing on the same edge as a RESP capture leaves that capture
    // with the old word because the packet is read before this update.
    always_ff @(posedge clock) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // Fetch FSM with registered handshake, response, fault and count outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_addrReady  <= 1'b0;
            r_dataValid  <= 1'b0;
            r_data       <= '0;
            r_err        <= 1'b0;
            r_fetchCount <= '0;
            r_latCount   <= '0;
            r_index      <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_dataValid <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_index <= w_reqIndex;
                        r_fault <= w_reqFault;
                        if (w_reqFault || bus.io_o_wen) begin
                            r_err <= 1'b1;
                        end
                        if (DIRECT_RESP && !stall_req) begin
                            r_state     <= RESP;
                            r_addrReady <= 1'b1;
                            r_dataValid <= 1'b1;
                            r_data      <= w_packet;
                            if (r_fetchCount != '1) begin
                                r_fetchCount <= r_fetchCount + 32'd1;
                            end
                        end else begin
                            r_state     <= WAIT;
                            r_addrReady <= 1'b0;
                            r_latCount  <= CNT_INIT;
                        end
                    end else begin
                        r_state     <= IDLE;
                        r_addrReady <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!stall_req) begin
                        if (r_latCount <= 4'd1) begin
                            r_state     <= RESP;
                            r_addrReady <= 1'b1;
                            r_dataValid <= 1'b1;
                            r_data      <= w_packet;
                            r_latCount  <= '0;
                            if (r_fetchCount != '1) begin
                                r_fetchCount <= r_fetchCount + 32'd1;
                            end
                        end else begin
                            r_latCount <= r_latCount - 4'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_addrReady <= 1'b0;
                end
            endcase
        end
    end

    assign bus.io_i_addr_ready = r_addrReady;
    assign bus.io_i_data_valid = r_dataValid;
    assign bus.io_i_data       = r_data;
    assign err                 = r_err;
    assign fetch_count         = r_fetchCount;

endmodule
